matriz_mult_seq: RTL and testbench

Parametrised sequential matrix multiplier for the coprocessor datapath, successor to the fixed 5x5 8-bit multiplier. Computes C = A x B for square matrices of run-time size 1..MAX_DIM using a single multiply-accumulate unit, one MAC per clock. It supports a start/busy/done handshake, signed or unsigned operands, and saturating or wrapping result narrowing with a sticky overflow flag. It sits between the coprocessor operand registers and the result write-back path.

---
 rtl/matriz_pkg.sv | 21 ++
 rtl/matriz_mult_seq_mac_sat.sv | 62 ++++++
 rtl/matriz_mult_seq.sv | 124 ++++++++++++
 tb/tb_matriz_mult_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the sequential matrix multiplier: element packing,
// FSM encoding and accumulator sizing.
package matriz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of element (r,c) in a flattened row-major matrix bus.
  function automatic int elem_idx(input int r, input int c, input int max_dim, input int data_w);
    return data_w * (c + max_dim * r);
  endfunction

  // Wide enough for up to 8 full-scale products of either signedness.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/matriz_mult_seq_mac_sat.sv
// Single multiply-accumulate lane with result narrowing (clamp or wrap) and range flag.
// Combinational product/sum/narrowing; only the accumulator is registered.
module mac_sat
  import matriz_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res,
  output logic              ovf
);

  localparam int ACC_W = acc_w(DATA_W);
  localparam int PAD   = ACC_W - DATA_W;

  localparam logic signed [ACC_W-1:0] S_MAX = {{(PAD+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(PAD+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] U_MAX = {{PAD{1'b0}}, {DATA_W{1'b1}}};

  logic signed [ACC_W-1:0] a_ext, b_ext, prod, sum, acc;
  logic hi, lo;

  always_comb begin
    a_ext = signed_mode ? {{PAD{a[DATA_W-1]}}, a} : {{PAD{1'b0}}, a};
    b_ext = signed_mode ? {{PAD{b[DATA_W-1]}}, b} : {{PAD{1'b0}}, b};
    prod  = a_ext * b_ext;
    sum   = acc + prod;
    if (signed_mode) begin
      hi = sum > S_MAX;
      lo = sum < S_MIN;
    end else begin
      hi = sum > U_MAX;
      lo = sum[ACC_W-1];
    end
    ovf = hi | lo;
    res = sum[DATA_W-1:0];
    if (SATURATE != 0) begin
      if (hi) res = signed_mode ? S_MAX[DATA_W-1:0] : U_MAX[DATA_W-1:0];
      if (lo) res = signed_mode ? S_MIN[DATA_W-1:0] : '0;
    end
  end

  // The final term of a dot product is consumed via sum, so the accumulator restarts at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
    end
  end

endmodule

// File: rtl/matriz_mult_seq.sv
// Sequential C = A x B for run-time n x n (1..MAX_DIM), one MAC per clock.
// Latency start->done is n^3+1 cycles; start is ignored while busy or done.
module matriz_mult_seq
  import matriz_pkg::*;
#(
  parameter int MAX_DIM  = 5,
  parameter int DATA_W   = 8,
  parameter int SATURATE = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [3:0]                        size,
  input  logic                              signed_mode,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matriz_a,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matriz_b,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matriz_resultante,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int MW = MAX_DIM * MAX_DIM * DATA_W;
  localparam int IW = $clog2(MW);

  state_t            state;
  logic [MW-1:0]     a_q, b_q;
  logic [3:0]        n_q, row, col, k, n_eff;
  logic              sgn_q;
  logic [IW-1:0]     a_idx, b_idx, c_idx;
  logic [DATA_W-1:0] a_el, b_el, res;
  logic              mac_ovf, last, acc_clr, mac_en;

  always_comb begin
    n_eff   = (size == 4'd0 || size > 4'(MAX_DIM)) ? 4'(MAX_DIM) : size;
    a_idx   = IW'(elem_idx(int'(row), int'(k), MAX_DIM, DATA_W));
    b_idx   = IW'(elem_idx(int'(k), int'(col), MAX_DIM, DATA_W));
    c_idx   = IW'(elem_idx(int'(row), int'(col), MAX_DIM, DATA_W));
    a_el    = a_q[a_idx +: DATA_W];
    b_el    = b_q[b_idx +: DATA_W];
    last    = (k == n_q - 4'd1);
    mac_en  = (state == RUN);
    acc_clr = (state == IDLE) && start;
  end

  mac_sat #(
    .DATA_W  (DATA_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (acc_clr),
    .en         (mac_en),
    .last       (last),
    .signed_mode(sgn_q),
    .a          (a_el),
    .b          (b_el),
    .res        (res),
    .ovf        (mac_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      a_q               <= '0;
      b_q               <= '0;
      n_q               <= '0;
      sgn_q             <= 1'b0;
      row               <= '0;
      col               <= '0;
      k                 <= '0;
      matriz_resultante <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q               <= matriz_a;
            b_q               <= matriz_b;
            n_q               <= n_eff;
            sgn_q             <= signed_mode;
            row               <= '0;
            col               <= '0;
            k                 <= '0;
            matriz_resultante <= '0;
            overflow          <= 1'b0;
            busy              <= 1'b1;
            state             <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            matriz_resultante[c_idx +: DATA_W] <= res;
            overflow <= overflow | mac_ovf;
            k        <= '0;
            if (col == n_q - 4'd1) begin
              col <= '0;
              if (row == n_q - 4'd1) begin
                row   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                row <= row + 4'd1;
              end
            end else begin
              col <= col + 4'd1;
            end
          end else begin
            k <= k + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matriz_mult_seq.sv
// Directed bench: table of hand-computed vectors run on saturating and wrapping instances,
// plus start/operand-change robustness and mid-run reset sequences.
module tb_matriz_mult_seq;

  localparam int MD = 5;
  localparam int DW = 8;
  localparam int MW = MD * MD * DW;

  typedef logic [MW-1:0] mat_t;

  typedef struct {
    logic [3:0] size;
    logic       sgn;
    mat_t       a;
    mat_t       b;
    mat_t       c_sat;
    logic       ovf_sat;
    mat_t       c_wrap;
    logic       ovf_wrap;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] size;
  logic       signed_mode;
  mat_t       a, b, c_s, c_w;
  logic       busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  matriz_mult_seq #(.MAX_DIM(MD), .DATA_W(DW), .SATURATE(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .signed_mode(signed_mode),
    .matriz_a(a), .matriz_b(b), .matriz_resultante(c_s),
    .busy(busy_s), .done(done_s), .overflow(ovf_s)
  );

  matriz_mult_seq #(.MAX_DIM(MD), .DATA_W(DW), .SATURATE(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .signed_mode(signed_mode),
    .matriz_a(a), .matriz_b(b), .matriz_resultante(c_w),
    .busy(busy_w), .done(done_w), .overflow(ovf_w)
  );

  task automatic check(input string name, input mat_t act, input mat_t exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic mat_t setel(input mat_t m, input int r, input int c, input logic [7:0] v);
    mat_t t;
    t = m;
    t[8'(DW * (c + MD * r)) +: DW] = v;
    return t;
  endfunction

  function automatic mat_t fill(input logic [7:0] v, input int n);
    mat_t t;
    t = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        t = setel(t, r, c, v);
    return t;
  endfunction

  function automatic vec_t mk(input logic [3:0] sz, input logic sg, input mat_t ma, input mat_t mb,
                              input mat_t cs, input logic os, input mat_t cw, input logic ow,
                              input int lat);
    vec_t v;
    v.size = sz; v.sgn = sg; v.a = ma; v.b = mb;
    v.c_sat = cs; v.ovf_sat = os; v.c_wrap = cw; v.ovf_wrap = ow; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int cyc;
    size = v.size; signed_mode = v.sgn; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    check($sformatf("v%0d busy_after_start", id), MW'(busy_s), MW'(1));
    while (!done_s && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d latency", id), MW'(cyc), MW'(v.lat));
    check($sformatf("v%0d done_wrap", id), MW'(done_w), MW'(1));
    check($sformatf("v%0d busy_at_done", id), MW'(busy_s), MW'(0));
    check($sformatf("v%0d c_sat", id), c_s, v.c_sat);
    check($sformatf("v%0d ovf_sat", id), MW'(ovf_s), MW'(v.ovf_sat));
    check($sformatf("v%0d c_wrap", id), c_w, v.c_wrap);
    check($sformatf("v%0d ovf_wrap", id), MW'(ovf_w), MW'(v.ovf_wrap));
    @(posedge clk); #1;
    check($sformatf("v%0d done_one_cycle", id), MW'(done_s), MW'(0));
    check($sformatf("v%0d c_held", id), c_s, v.c_sat);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    mat_t ida, idb, a2, b2, c2;
    int   cyc, dcount, dcyc;

    ida = '0; idb = '0;
    for (int i = 0; i < MD; i++) ida = setel(ida, i, i, 8'd1);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        idb = setel(idb, r, c, 8'(5 * r + c));
    a2 = setel(setel(setel(setel(fill(8'd9, MD), 0, 0, 8'd1), 0, 1, 8'd2), 1, 0, 8'd3), 1, 1, 8'd4);
    b2 = setel(setel(setel(setel(fill(8'd9, MD), 0, 0, 8'd5), 0, 1, 8'd6), 1, 0, 8'd7), 1, 1, 8'd8);
    c2 = setel(setel(setel(setel(mat_t'(0), 0, 0, 8'd19), 0, 1, 8'd22), 1, 0, 8'd43), 1, 1, 8'd50);

    vt[0] = mk(4'd5, 1'b0, ida, idb, idb, 1'b0, idb, 1'b0, 126);
    vt[1] = mk(4'd2, 1'b0, a2, b2, c2, 1'b0, c2, 1'b0, 9);
    vt[2] = mk(4'd3, 1'b1, fill(8'hFE, 3), fill(8'd3, 3), fill(8'hEE, 3), 1'b0, fill(8'hEE, 3), 1'b0, 28);
    vt[3] = mk(4'd5, 1'b0, fill(8'd16, 5), fill(8'd16, 5), fill(8'hFF, 5), 1'b1, '0, 1'b1, 126);
    vt[4] = mk(4'd1, 1'b0, setel(fill(8'd7, 5), 0, 0, 8'd200), setel(fill(8'd7, 5), 0, 0, 8'd2),
               setel('0, 0, 0, 8'hFF), 1'b1, setel('0, 0, 0, 8'h90), 1'b1, 2);
    vt[5] = mk(4'd2, 1'b1, fill(8'h80, 2), fill(8'h7F, 2), fill(8'h80, 2), 1'b1, '0, 1'b1, 9);
    vt[6] = mk(4'd3, 1'b0, fill(8'hFE, 3), fill(8'd3, 3), fill(8'hFF, 3), 1'b1, fill(8'hEE, 3), 1'b1, 28);
    vt[7] = mk(4'd0, 1'b0, ida, idb, idb, 1'b0, idb, 1'b0, 126);
    vt[8] = mk(4'd9, 1'b0, ida, idb, idb, 1'b0, idb, 1'b0, 126);

    reset_n = 1'b0; start = 1'b0; size = 4'd0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset c", c_s, '0);
    check("reset busy", MW'(busy_s), MW'(0));
    check("reset done", MW'(done_s), MW'(0));
    check("reset ovf", MW'(ovf_s), MW'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle busy", MW'(busy_s), MW'(0));

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // start held high and A rewritten while running
    size = 4'd2; signed_mode = 1'b0; a = a2; b = b2; start = 1'b1;
    @(posedge clk); #1;
    cyc = 1; dcount = 0; dcyc = 0;
    while (cyc <= 30) begin
      if (done_s) begin
        dcount++;
        dcyc = cyc;
      end
      start = (cyc <= 5);
      if (cyc == 2) a = fill(8'd1, MD);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("hs done_count", MW'(dcount), MW'(1));
    check("hs done_cycle", MW'(dcyc), MW'(9));
    check("hs c", c_s, c2);
    check("hs ovf", MW'(ovf_s), MW'(0));

    // reset at cycle 40 of a saturating n=5 run
    size = 4'd5; signed_mode = 1'b0; a = fill(8'd16, 5); b = fill(8'd16, 5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid ovf_before_reset", MW'(ovf_s), MW'(1));
    reset_n = 1'b0;
    #1;
    check("mid c_sat", c_s, '0);
    check("mid c_wrap", c_w, '0);
    check("mid ovf", MW'(ovf_s), MW'(0));
    check("mid busy", MW'(busy_s), MW'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    dcount = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_s || done_w || busy_s) dcount++;
    end
    check("mid no_resume", MW'(dcount), MW'(0));
    run_vec(vt[0], 100);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
